// File: rtl/ddc_iq_nco.sv
// rtl/ddc_iq_nco.sv - NCO-based I/Q downconverter: phase, LUT, multiply, round/saturate.
// DDC_IQ_NCO_RND_EN selects round-half-up output scaling; otherwise the product is truncated.
module ddc_iq_nco #(
    parameter int DIN_W     = 16,
    parameter int NCO_W     = 16,
    parameter int PHASE_W   = 28,
    parameter int LUT_AW    = 10,
    parameter int DOUT_W    = 16,
    parameter int OUT_SHIFT = 15
) (
    input  logic               clk_200m,
    input  logic               cfg_rst_n,
    input  logic [DIN_W-1:0]   din,
    input  logic               din_valid,
    input  logic [PHASE_W-1:0] fcw,
    input  logic               fcw_we,
    input  logic [PHASE_W-1:0] phase_ofs,
    input  logic               phase_clr,
    input  logic [1:0]         gain_sh,
    input  logic               sat_clr,
    output logic [DOUT_W-1:0]  dout_i,
    output logic [DOUT_W-1:0]  dout_q,
    output logic               dout_valid,
    output logic [15:0]        sat_cnt
);
    localparam int  PW    = DIN_W + NCO_W;
    localparam int  LUT_N = 1 << LUT_AW;
    localparam real AMP   = real'((1 << (NCO_W - 1)) - 1);
    localparam logic signed [PW:0] SAT_HI = (PW+1)'((1 << (DOUT_W - 1)) - 1);
    localparam logic signed [PW:0] SAT_LO = ~SAT_HI;

    function automatic logic [NCO_W-1:0] lut_val(input int k, input bit sel_sin);
        real ang;
        real v;
        ang = 6.283185307179586 * real'(k) / real'(LUT_N);
        v   = sel_sin ? AMP * $sin(ang) : AMP * $cos(ang);
        return NCO_W'($rtoi(v >= 0.0 ? v + 0.5 : v - 0.5));
    endfunction

    logic [NCO_W-1:0] cos_rom [LUT_N];
    logic [NCO_W-1:0] sin_rom [LUT_N];
    for (genvar k = 0; k < LUT_N; k++) begin : g_rom
        assign cos_rom[k] = lut_val(k, 1'b0);
        assign sin_rom[k] = lut_val(k, 1'b1);
    end

    // Scale by 2^-(OUT_SHIFT-gsh) with one guard bit so the rounding add cannot overflow.
    function automatic void shape(input logic signed [PW-1:0] p, input logic [1:0] gsh,
                                  output logic [DOUT_W-1:0] y, output logic sat);
        logic signed [PW:0] ext;
        int s;
        s   = OUT_SHIFT - int'(gsh);
        ext = {p[PW-1], p};
`ifdef DDC_IQ_NCO_RND_EN
        ext = ext + ({{PW{1'b0}}, 1'b1} << (s - 1));
`endif
        ext = ext >>> s;
        sat = 1'b1;
        if (ext > SAT_HI)      y = SAT_HI[DOUT_W-1:0];
        else if (ext < SAT_LO) y = SAT_LO[DOUT_W-1:0];
        else begin
            y   = ext[DOUT_W-1:0];
            sat = 1'b0;
        end
    endfunction

    logic [PHASE_W-1:0] acc, fcw_reg, phase_sum;
    logic               unused_frac;
    assign phase_sum   = acc + phase_ofs;
    assign unused_frac = ^phase_sum[PHASE_W-LUT_AW-1:0];

    logic [LUT_AW-1:0]        s1_idx;
    logic signed [DIN_W-1:0]  s1_din, s2_din;
    logic [1:0]               s1_gsh, s2_gsh, s3_gsh;
    logic                     s1_vld, s2_vld, s3_vld;
    logic signed [NCO_W-1:0]  s2_cos, s2_sin;
    logic signed [PW-1:0]     s3_pi, s3_pq;
    logic [DOUT_W-1:0]        res_i, res_q;
    logic                     sat_i, sat_q;

    always_comb begin
        shape(s3_pi, s3_gsh, res_i, sat_i);
        shape(s3_pq, s3_gsh, res_q, sat_q);
    end

    always_ff @(posedge clk_200m or negedge cfg_rst_n) begin
        if (!cfg_rst_n) begin
            acc        <= '0;
            fcw_reg    <= '0;
            s1_idx     <= '0;
            s1_din     <= '0;
            s1_gsh     <= '0;
            s1_vld     <= 1'b0;
            s2_cos     <= '0;
            s2_sin     <= '0;
            s2_din     <= '0;
            s2_gsh     <= '0;
            s2_vld     <= 1'b0;
            s3_pi      <= '0;
            s3_pq      <= '0;
            s3_gsh     <= '0;
            s3_vld     <= 1'b0;
            dout_i     <= '0;
            dout_q     <= '0;
            dout_valid <= 1'b0;
            sat_cnt    <= '0;
        end else begin
            if (fcw_we) fcw_reg <= fcw;
            // The sample in this cycle has already captured the pre-update phase below.
            if (phase_clr)      acc <= '0;
            else if (din_valid) acc <= acc + fcw_reg;

            s1_idx <= phase_sum[PHASE_W-1 -: LUT_AW];
            s1_din <= din;
            s1_gsh <= gain_sh;
            s1_vld <= din_valid;

            s2_cos <= cos_rom[s1_idx];
            s2_sin <= sin_rom[s1_idx];
            s2_din <= s1_din;
            s2_gsh <= s1_gsh;
            s2_vld <= s1_vld;

            s3_pi  <= s2_din * s2_cos;
            s3_pq  <= s2_din * s2_sin;
            s3_gsh <= s2_gsh;
            s3_vld <= s2_vld;

            dout_valid <= s3_vld;
            if (s3_vld) begin
                dout_i <= res_i;
                dout_q <= res_q;
            end
            if (sat_clr)
                sat_cnt <= '0;
            else if (s3_vld && (sat_i || sat_q) && sat_cnt != 16'hFFFF)
                sat_cnt <= sat_cnt + 16'd1;
        end
    end
endmodule

// File: doc/ddc_iq_nco.md
DDC_IQ_NCO -- requirements
Module: ddc_iq_nco

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset: clk_200m (all logic on its rising edge), cfg_rst_n.
REQ-002 The block SHALL have these parameters:
- DIN_W, 16: input sample width, signed.
- NCO_W, 16: sine/cosine width, signed.
- PHASE_W, 28: phase accumulator, FCW and offset width.
- LUT_AW, 10: LUT address width (top bits of phase).
- DOUT_W, 16: output width, signed.
- OUT_SHIFT, 15: product right-shift at gain_sh=0.
REQ-003 The block SHALL have these ports:
- clk_200m, in, 1: clock.
- cfg_rst_n, in, 1: async reset, active low.
- din, in, DIN_W: signed real IF sample.
- din_valid, in, 1: din qualifier.
- fcw, in, PHASE_W: frequency control word.
- fcw_we, in, 1: load fcw.
- phase_ofs, in, PHASE_W: static phase offset.
- phase_clr, in, 1: synchronous phase accumulator clear.
- gain_sh, in, 2: extra gain 2^gain_sh.
- sat_clr, in, 1: clear sat_cnt.
- dout_i, out, DOUT_W: in-phase result.
- dout_q, out, DOUT_W: quadrature result.
- dout_valid, out, 1: output qualifier.
- sat_cnt, out, 16: saturation event count.

Function
REQ-004 fcw_reg SHALL load fcw on a cycle with fcw_we=1 and be used for increments from the next cycle.
REQ-005 The accumulator acc SHALL advance by fcw_reg (mod 2^PHASE_W) only on cycles with din_valid=1; a sample accepted at cycle t SHALL use acc as it was before that increment.
REQ-006 phase_clr=1 SHALL set acc to 0 and take priority over increment; a sample accepted in the same cycle SHALL still use the pre-clear acc; simultaneous fcw_we SHALL still load.
REQ-007 LUT index k SHALL be the top LUT_AW bits of (acc + phase_ofs) mod 2^PHASE_W, with A=2^(NCO_W-1)-1, cos=round(A*cos(2*pi*k/2^LUT_AW)) and sin=round(A*sin(2*pi*k/2^LUT_AW)).
REQ-008 Products SHALL be full-precision signed: pi=din*cos and pq=din*sin, each DIN_W+NCO_W bits.
REQ-009 The shift SHALL be s=OUT_SHIFT-gain_sh, with result = floor((p + 2^(s-1)) / 2^s) computed without intermediate overflow.
REQ-010 The result SHALL saturate to [-2^(DOUT_W-1), 2^(DOUT_W-1)-1].
REQ-011 din_valid at cycle t SHALL give dout_valid=1 with matching dout_i/dout_q at cycle t+4.
- The pipeline SHALL be phase, LUT, multiply, round/saturate.
- Full throughput, no stalls.
- dout_i/dout_q SHALL hold their last value while dout_valid=0.
REQ-012 sat_cnt SHALL increment by 1 per output sample in which either channel saturated, and stick at 65535.
REQ-013 sat_clr SHALL zero sat_cnt and win over a simultaneous increment.
REQ-014 gain_sh and phase_ofs SHALL be sampled with the sample they apply to (pipeline-aligned).

Reset
REQ-015 While cfg_rst_n=0 the following SHALL be 0: acc, fcw_reg, all pipeline registers, dout_i, dout_q, dout_valid, sat_cnt.
REQ-016 Samples in flight at reset assertion SHALL be discarded, and none SHALL emerge after release.
REQ-017 The first din_valid after release SHALL use phase 0 plus phase_ofs.

Configuration
REQ-018 Rounding SHALL depend on macro DDC_IQ_NCO_RND_EN:
- Defined: REQ-009 rounding applies.
- Undefined: result = floor(p / 2^s) (truncation); all else unchanged.

Verification
REQ-019 The bench SHALL cover these directed scenarios (parameter defaults):
- RND_EN defined, fcw=0, ofs=0, din=16384 continuous valid -> dout_i=16384, dout_q=0, latency exactly 4 cycles.
- Same stimulus, RND_EN undefined -> dout_i=16383, dout_q=0.
- fcw=2^26 (quarter turn), din=16384 -> dout_i 16384,0,-16384,0 and dout_q 0,16384,0,-16384, repeating.
- fcw=0, phase_ofs=2^26, din=16384 -> dout_i=0, dout_q=16384.
- fcw=0, gain_sh=1, din=20000, 3 samples -> dout_i=32767, sat_cnt=3; then sat_clr -> 0; sat_clr with simultaneous saturation -> 0.
- Gapped din_valid plus mid-stream phase_clr and cfg_rst_n pulse -> phase advances only on valid samples; restarts at 0 after clear/reset; no stale dout_valid after reset.
